// File: rtl/fir_prog_pipe.sv
// Streaming FIR filter with run-time coefficients, a programmable tap count and valid/ready flow control.
// Optional macro FIR_SAT_EN: round, shift right by SHIFT and saturate the output to DATA_W with a sticky sat_flag.
module fir_prog_pipe #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int MAX_TAPS = 8,
    parameter int SHIFT    = 15,
    localparam int AW      = $clog2(MAX_TAPS),
    localparam int OUT_W   = DATA_W + COEF_W + $clog2(MAX_TAPS),
`ifdef FIR_SAT_EN
    localparam int OD_W    = DATA_W
`else
    localparam int OD_W    = OUT_W
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [COEF_W-1:0] cfg_coef,
    input  logic [4:0]        tap_num,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OD_W-1:0]   out_data,
    output logic              sat_flag
);
    // Arrays are padded to an even length so the pairwise adder needs no odd-tap special case.
    localparam int NP = (MAX_TAPS + 1) / 2;
    localparam int NT = 2 * NP;
    localparam int PW = DATA_W + COEF_W;
    localparam int SW = PW + 1;

    logic signed [DATA_W-1:0] d_q  [NT];
    logic signed [DATA_W-1:0] d_d  [NT];
    logic signed [COEF_W-1:0] c_q  [NT];
    logic signed [COEF_W-1:0] cs_q [NT];
    logic signed [PW-1:0]     p_q  [NT];
    logic signed [PW-1:0]     p_d  [NT];
    logic signed [SW-1:0]     s_q  [NP];
    logic signed [SW-1:0]     s_d  [NP];
    logic signed [OUT_W-1:0]  sum_d;
    logic [OD_W-1:0]          out_data_q;
    logic [OD_W-1:0]          out_data_d;
    logic [4:0]               tap_q;
    logic [4:0]               tap_d;
    logic                     v0_q, v1_q, v2_q, out_valid_q;
    logic                     adv, accept, empty, cfg_hit;

    // Handshake: a transfer happens on any edge where valid & ready are both high; ready never waits on valid.
    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid & adv;
    assign empty     = ~(v0_q | v1_q | v2_q | out_valid_q);
    assign cfg_hit   = cfg_we && (32'(cfg_addr) < 32'(MAX_TAPS));
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    always_comb begin
        tap_d = tap_num;
        if (tap_num == 5'd0) begin
            tap_d = 5'd1;
        end else if (tap_num > 5'(MAX_TAPS)) begin
            tap_d = 5'(MAX_TAPS);
        end
    end

    always_comb begin
        for (int k = 0; k < NT; k++) begin
            d_d[k] = (k == 0) ? in_data : d_q[(k == 0) ? 0 : k - 1];
        end
    end

    // Products use the coefficient snapshot taken when the sample entered the delay line.
    always_comb begin
        for (int k = 0; k < NT; k++) begin
            p_d[k] = '0;
            if (5'(k) < tap_q) begin
                p_d[k] = PW'(cs_q[k]) * PW'(d_q[k]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NP; j++) begin
            s_d[j] = SW'(p_q[2*j]) + SW'(p_q[2*j+1]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int j = 0; j < NP; j++) begin
            sum_d = sum_d + OUT_W'(s_q[j]);
        end
    end

`ifdef FIR_SAT_EN
    localparam logic signed [OUT_W:0] SAT_MAX = (OUT_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [OUT_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [OUT_W:0] RND     = (OUT_W+1)'(1 << (SHIFT - 1));

    logic signed [OUT_W:0] rnd_w;
    logic signed [OUT_W:0] sh_w;
    logic                  clip_d;
    logic                  sat_q;

    always_comb begin
        rnd_w      = (OUT_W+1)'(sum_d) + RND;
        sh_w       = rnd_w >>> SHIFT;
        clip_d     = 1'b0;
        out_data_d = sh_w[DATA_W-1:0];
        if (sh_w > SAT_MAX) begin
            out_data_d = SAT_MAX[DATA_W-1:0];
            clip_d     = 1'b1;
        end else if (sh_w < SAT_MIN) begin
            out_data_d = SAT_MIN[DATA_W-1:0];
            clip_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sat_q <= 1'b0;
        end else if (adv && v2_q && clip_d) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    always_comb begin
        out_data_d = sum_d;
    end

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NT; k++) begin
                d_q[k]  <= '0;
                c_q[k]  <= '0;
                cs_q[k] <= '0;
                p_q[k]  <= '0;
            end
            for (int j = 0; j < NP; j++) begin
                s_q[j] <= '0;
            end
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            tap_q       <= 5'd1;
        end else begin
            if (cfg_hit) begin
                c_q[cfg_addr] <= cfg_coef;
            end
            if (empty) begin
                tap_q <= tap_d;
            end
            if (clear) begin
                for (int k = 0; k < NT; k++) begin
                    d_q[k] <= '0;
                end
                v0_q        <= 1'b0;
                v1_q        <= 1'b0;
                v2_q        <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (adv) begin
                if (accept) begin
                    d_q  <= d_d;
                    cs_q <= c_q;
                end
                v0_q        <= accept;
                p_q         <= p_d;
                v1_q        <= v0_q;
                s_q         <= s_d;
                v2_q        <= v1_q;
                out_valid_q <= v2_q;
                if (v2_q) begin
                    out_data_q <= out_data_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_fir_prog_pipe.sv
// Directed bench for fir_prog_pipe: impulse, back-pressure, tap-count changes, signed extremes and clear.
module tb_fir_prog_pipe;
    localparam int DATA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int MAX_TAPS = 8;
    localparam int AW       = 3;
    localparam int OUT_W    = 35;
`ifdef FIR_SAT_EN
    localparam int OD_W     = DATA_W;
`else
    localparam int OD_W     = OUT_W;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_we = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [COEF_W-1:0] cfg_coef = '0;
    logic [4:0]        tap_num = 5'd1;
    logic              clear = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [OD_W-1:0]   out_data;
    logic              sat_flag;

    int checks = 0;
    int errors = 0;
    logic signed [OD_W-1:0] exp_q[$];

    int xs[10]  = '{5, -7, 100, -2000, 32767, -32768, 1, 0, 12, -3};
    int cs2[4]  = '{3, -1, 2, 5};

    fir_prog_pipe dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_coef(cfg_coef),
        .tap_num(tap_num), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, longint got, longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint fit(longint y);
`ifdef FIR_SAT_EN
        longint r;
        r = (y + 64'sd16384) >>> 15;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r;
`else
        return y;
`endif
    endfunction

    function automatic longint golden(int n);
        longint y = 0;
        for (int k = 0; k < 4; k++) begin
            if (n - k >= 0) y += longint'(cs2[k]) * longint'(xs[n-k]);
        end
        return y;
    endfunction

    // Scoreboard: every completed output transfer is checked in order against the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!out_ready) begin
                check("in_ready_stall", in_ready, 0);
            end else begin
                check("out_pending", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("out_data", $signed(out_data), exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(int addr, int val);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_coef = COEF_W'(val);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic send_cfg(int x, longint y, bit do_cfg, int addr, int val);
        int n = 0;
        in_valid = 1'b1;
        in_data  = DATA_W'(x);
        if (do_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = AW'(addr);
            cfg_coef = COEF_W'(val);
        end
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready", in_ready, 1);
        if (in_ready) begin
            @(posedge clk);
            #1;
            exp_q.push_back(OD_W'(fit(y)));
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic send(int x, longint y);
        send_cfg(x, y, 1'b0, 0, 0);
    endtask

    task automatic check_latency(string tag);
        check({tag, "_lat0"}, out_valid, 0);
        tick();
        check({tag, "_lat1"}, out_valid, 0);
        tick();
        check({tag, "_lat2"}, out_valid, 0);
        tick();
        check({tag, "_lat3"}, out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_sat_flag", sat_flag, 0);

        // Impulse through 4 taps
        write_coef(0, 1); write_coef(1, 2); write_coef(2, 3); write_coef(3, 4);
        tap_num = 5'd4;
        drain();
        send(1, 1);
        check_latency("impulse");
        send(0, 2); send(0, 3); send(0, 4); send(0, 0);
        drain();

        // Back-pressure in the middle of a 10-sample stream
        pulse_clear();
        write_coef(0, cs2[0]); write_coef(1, cs2[1]); write_coef(2, cs2[2]); write_coef(3, cs2[3]);
        drain();
        fork
            begin
                for (int i = 0; i < 10; i++) send(xs[i], golden(i));
            end
            begin
                repeat (6) tick();
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
            end
        join
        drain();

        // Tap count change while busy, then 0 -> 1 and 20 -> MAX_TAPS
        pulse_clear();
        write_coef(0, 1); write_coef(1, 10); write_coef(2, 100);
        write_coef(3, 1000); write_coef(4, 10000); write_coef(5, -1);
        tap_num = 5'd6;
        drain();
        send(1, 1); send(2, 12); send(3, 123);
        tap_num = 5'd2;
        drain();
        send(4, 34); send(5, 45);
        tap_num = 5'd0;
        drain();
        send(6, 6);
        write_coef(6, 2); write_coef(7, 3);
        tap_num = 5'd20;
        drain();
        send(7, 34567);
        drain();

        // Most negative sample times most negative coefficient
        write_coef(0, -32768);
        tap_num = 5'd1;
        drain();
        send(-32768, 64'sd1073741824);
        // Coefficient written on the accept edge applies only to later samples
        send_cfg(3, -98304, 1'b1, 0, 7);
        send(2, 14);
        drain();

        // Clear mid-stream with a sample offered on the clear edge
        write_coef(1, 5);
        tap_num = 5'd2;
        drain();
        send(10, 80);
        send(20, 190);
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = DATA_W'(99);
        pulse_clear();
        in_valid = 1'b0;
        check("clear_out_valid", out_valid, 0);
        send(4, 28);
        check_latency("after_clear");
        send(1, 27);
        drain();

`ifdef FIR_SAT_EN
        pulse_clear();
        check("sat_cleared", sat_flag, 0);
        write_coef(0, 32767); write_coef(1, 32767);
        drain();
        send(32767, 64'sd1073676289);
        send(32767, 64'sd2147352578);
        drain();
        check("sat_set", sat_flag, 1);
        pulse_clear();
        check("sat_clear", sat_flag, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
